instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0040_0004, the redirect target for exc.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port stall  input  1  downstream busy (multi-cycle mul/div); freezes fetch.
REQ-006 SHALL have ports br_taken, jmp, exc, eret  input  1 each  redirect requests from the execute stage.
REQ-007 SHALL have ports br_target, jmp_target, epc  input  32 each  redirect addresses.
REQ-008 SHALL have port imem_addr  output  11  word address, (pc_q - RESET_PC) >> 2, bits [10:0]; combinational from pc_q.
REQ-009 SHALL have port imem_rdata  input  32  instruction word, asynchronous read of imem_addr.
REQ-010 SHALL have port id_instr  output  32  registered instruction feeding the decoder's imem_instr input.
REQ-011 SHALL have ports id_pc and id_pc_plus4  output  32 each  address of id_instr, and that address + 4.
REQ-012 SHALL have port id_valid  output  1  id_instr is a real instruction, not a bubble.
REQ-013 SHALL have port fetch_cnt  output  32  count of instructions delivered (see Configuration).

Function
REQ-014 SHALL hold the fetch PC in register pc_q.
REQ-015 SHALL implement states BOOT, RUN and HOLD.
REQ-016 SHALL leave BOOT for RUN one cycle after rst_n deasserts, with no fetch and id_valid=0 during BOOT.
REQ-017 SHALL, in RUN with stall=0 and no redirect: latch id_instr<=imem_rdata, id_pc<=pc_q, id_valid<=1, and pc_q<=pc_q+4 (one-cycle latency from imem_addr to id_instr).
REQ-018 SHALL resolve redirect priority as exc > eret > jmp > br_taken; the target is EXC_VECTOR, epc, jmp_target or br_target respectively.
REQ-019 SHALL, on a redirect in RUN with stall=0, set pc_q to the target and id_valid<=0, squashing the word fetched that cycle (no delay slot).
REQ-020 SHALL, when stall=1, enter or stay in HOLD with pc_q, id_instr, id_pc and id_valid unchanged.
REQ-021 SHALL capture any redirect that occurs during HOLD into a pending register (valid flag + 32-bit target); a later request overwrites it only if it has equal or higher priority.
REQ-022 SHALL, on the first cycle stall=0 after HOLD, apply the pending redirect (pc_q<=target, id_valid<=0, pending cleared) and return to RUN; if nothing is pending, SHALL perform a normal RUN fetch that cycle.
REQ-023 SHALL, when stall falls in the same cycle a new redirect arrives, apply whichever of the new and pending redirects has higher priority (ties go to the new one).
REQ-024 SHALL wrap pc_q+4 modulo 2^32 and SHALL NOT check alignment; imem_addr simply truncates.
REQ-025 SHALL compute id_pc_plus4 combinationally as id_pc+4.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: pc_q=RESET_PC, id_instr=0, id_pc=0, id_valid=0, pending cleared, fetch_cnt=0, state=BOOT.
REQ-027 SHALL treat reset asserted mid-HOLD or with a redirect pending as overriding everything; the pending redirect is discarded.

Configuration
REQ-028 SHALL, with IFETCH_ICOUNT_EN defined, increment fetch_cnt (wrapping modulo 2^32) on every cycle id_valid is loaded with 1.
REQ-029 SHALL, with IFETCH_ICOUNT_EN undefined, tie fetch_cnt to 0 and include no counter register.

Verification
REQ-030 SHALL cover: release reset, stall=0, imem word i = 0x2000_0000+i -> BOOT one cycle, then id_pc=0x00400000, 0x00400004, ... and id_instr=0x20000000, 0x20000001, ...
REQ-031 SHALL cover: jmp=1 with jmp_target=0x00400100 while pc_q=0x00400008 -> next cycle id_valid=0, pc_q=0x00400100; the cycle after, id_pc=0x00400100.
REQ-032 SHALL cover: exc=1 and br_taken=1 in the same cycle -> pc_q=0x00400004 and the branch is ignored.
REQ-033 SHALL cover: stall held 5 cycles with br_taken (target 0x00400040) in cycle 2 and eret (epc 0x00400080) in cycle 4 -> outputs frozen throughout; after stall falls, pc_q=0x00400080 and id_valid=0.
REQ-034 SHALL cover: rst_n pulsed low mid-HOLD with a redirect pending -> pc_q returns to 0x00400000 immediately and the pending redirect is never applied.
REQ-035 SHALL cover, with IFETCH_ICOUNT_EN defined: 10 sequential fetches plus 1 squashed redirect -> fetch_cnt=10.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, redirect arbitration, and stall hold with a pending redirect.
// The optional delivered-instruction counter is enabled by defining IFETCH_ICOUNT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jmp,
  input  logic        exc,
  input  logic        eret,
  input  logic [31:0] br_target,
  input  logic [31:0] jmp_target,
  input  logic [31:0] epc,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_r, state_s;
  logic [31:0] pc_q, pc_s;
  logic [31:0] id_instr_s, id_pc_s;
  logic        id_valid_s;
  logic        pend_valid_r, pend_valid_s;
  logic [1:0]  pend_prio_r, pend_prio_s;
  logic [31:0] pend_target_r, pend_target_s;

  logic        new_valid_s;
  logic [1:0]  new_prio_s;
  logic [31:0] new_target_s;
  logic        take_new_s;
  logic        redir_valid_s;
  logic [31:0] redir_target_s;

  assign imem_addr   = 11'((pc_q - RESET_PC) >> 2);
  assign id_pc_plus4 = id_pc + 32'd4;

  // Encode the incoming redirect: priority 3 (exc) down to 0 (branch).
  always_comb begin
    new_valid_s  = exc | eret | jmp | br_taken;
    new_prio_s   = 2'd0;
    new_target_s = 32'h0;
    if (exc) begin
      new_prio_s   = 2'd3;
      new_target_s = EXC_VECTOR;
    end else if (eret) begin
      new_prio_s   = 2'd2;
      new_target_s = epc;
    end else if (jmp) begin
      new_prio_s   = 2'd1;
      new_target_s = jmp_target;
    end else if (br_taken) begin
      new_prio_s   = 2'd0;
      new_target_s = br_target;
    end else begin
      new_prio_s   = 2'd0;
      new_target_s = 32'h0;
    end
  end

  // A new request beats the pending one on equal or higher priority.
  assign take_new_s     = new_valid_s & (~pend_valid_r | (new_prio_s >= pend_prio_r));
  assign redir_valid_s  = new_valid_s | pend_valid_r;
  assign redir_target_s = take_new_s ? new_target_s : pend_target_r;

  // Next-state logic for the fetch FSM, PC and decode-stage registers.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_q;
    id_instr_s    = id_instr;
    id_pc_s       = id_pc;
    id_valid_s    = id_valid;
    pend_valid_s  = pend_valid_r;
    pend_prio_s   = pend_prio_r;
    pend_target_s = pend_target_r;
    case (state_r)
      BOOT: begin
        state_s = RUN;
      end
      RUN, HOLD: begin
        if (stall) begin
          state_s = HOLD;
          if (take_new_s) begin
            pend_valid_s  = 1'b1;
            pend_prio_s   = new_prio_s;
            pend_target_s = new_target_s;
          end else begin
            pend_valid_s  = pend_valid_r;
          end
        end else begin
          state_s       = RUN;
          pend_valid_s  = 1'b0;
          pend_prio_s   = 2'd0;
          pend_target_s = 32'h0;
          if (redir_valid_s) begin
            pc_s       = redir_target_s;
            id_valid_s = 1'b0;
          end else begin
            id_instr_s = imem_rdata;
            id_pc_s    = pc_q;
            id_valid_s = 1'b1;
            pc_s       = pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // State registers with asynchronous reset; reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_q          <= RESET_PC;
      id_instr      <= 32'h0;
      id_pc         <= 32'h0;
      id_valid      <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_prio_r   <= 2'd0;
      pend_target_r <= 32'h0;
    end else begin
      state_r       <= state_s;
      pc_q          <= pc_s;
      id_instr      <= id_instr_s;
      id_pc         <= id_pc_s;
      id_valid      <= id_valid_s;
      pend_valid_r  <= pend_valid_s;
      pend_prio_r   <= pend_prio_s;
      pend_target_r <= pend_target_s;
    end
  end

`ifdef IFETCH_ICOUNT_EN
  logic        fetch_s;
  logic [31:0] cnt_r;

  assign fetch_s = (state_r != BOOT) & ~stall & ~redir_valid_s;

  // Count every word delivered to decode as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'h0;
    end else if (fetch_s) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign fetch_cnt = cnt_r;
`else
  assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked against a
// request-queue reference model of the fetch rules.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, exc = 1'b0, eret = 1'b0;
  logic [31:0] br_target = 32'h0, jmp_target = 32'h0, epc = 32'h0;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata, id_instr, id_pc, id_pc_plus4, fetch_cnt;
  logic        id_valid;

  logic [31:0] mem [0:2047];
  assign imem_rdata = mem[imem_addr];

  instr_fetch #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .jmp(jmp),
    .exc(exc), .eret(eret), .br_target(br_target), .jmp_target(jmp_target),
    .epc(epc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed = 0;

  // Reference model: architectural view only, redirects collected while stalled.
  typedef struct { int prio; logic [31:0] tgt; } req_t;
  req_t        pend_q[$];
  logic        m_boot;
  logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
  logic        m_valid;

  function automatic logic [10:0] word_index(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - RESET_PC) >> 2;
    return off[10:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_boot = 1'b1; m_pc = RESET_PC; m_instr = 32'h0; m_idpc = 32'h0;
    m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step();
    req_t r, best;
    bit   have;
    have = (exc | eret | jmp | br_taken);
    if (exc)       begin r.prio = 3; r.tgt = EXC_VECTOR; end
    else if (eret) begin r.prio = 2; r.tgt = epc; end
    else if (jmp)  begin r.prio = 1; r.tgt = jmp_target; end
    else           begin r.prio = 0; r.tgt = br_target; end
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (have) pend_q.push_back(r);
      if (!stall) begin
        if (pend_q.size() > 0) begin
          best = pend_q[0];
          foreach (pend_q[i]) if (pend_q[i].prio >= best.prio) best = pend_q[i];
          m_pc = best.tgt;
          m_valid = 1'b0;
          pend_q.delete();
        end else begin
          m_instr = mem[word_index(m_pc)];
          m_idpc = m_pc;
          m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"}, {21'h0, imem_addr}, {21'h0, word_index(m_pc)});
    check({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, m_valid});
    check({tag, ".id_instr"}, id_instr, m_instr);
    check({tag, ".id_pc"}, id_pc, m_idpc);
    check({tag, ".id_pc_plus4"}, id_pc_plus4, m_idpc + 32'd4);
`ifdef IFETCH_ICOUNT_EN
    check({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
`else
    check({tag, ".fetch_cnt"}, fetch_cnt, 32'h0);
`endif
  endtask

  task automatic step(input string tag, input logic s, input logic e, input logic er,
                      input logic j, input logic b);
    stall = s; exc = e; eret = er; jmp = j; br_taken = b;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("boot", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("boot.no_fetch", {31'h0, id_valid}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h2000_0000 + i;
    model_reset();
    #12;
    check_all("reset");
    check("reset.imem_addr0", {21'h0, imem_addr}, 32'h0);

    // Sequential fetch after reset
    release_reset();
    step("seq0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq0.pc", id_pc, 32'h0040_0000);
    check("seq0.instr", id_instr, 32'h2000_0000);
    step("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq1.pc", id_pc, 32'h0040_0004);
    check("seq1.instr", id_instr, 32'h2000_0001);

    // Jump while pc_q = 0x00400008
    jmp_target = 32'h0040_0100;
    step("jmp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("jmp.squash", {31'h0, id_valid}, 32'h0);
    check("jmp.addr", {21'h0, imem_addr}, 32'h40);
    step("jmp_next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jmp_next.pc", id_pc, 32'h0040_0100);

    // exc beats a simultaneous branch
    br_target = 32'h0040_0200;
    step("exc_br", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("exc_br.addr", {21'h0, imem_addr}, 32'h1);

    // Stall five cycles, branch in cycle 2, eret in cycle 4
    step("pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    br_target = 32'h0040_0040; epc = 32'h0040_0080;
    step("hold1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hold2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hold3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hold4", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("unhold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("unhold.addr", {21'h0, imem_addr}, 32'h20);
    check("unhold.valid", {31'h0, id_valid}, 32'h0);

    // Reset mid-HOLD with a jump pending
    jmp_target = 32'h0040_0300;
    step("h_jmp", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("h_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    stall = 1'b0;
    model_reset();
    #1;
    check("rst_mid.addr", {21'h0, imem_addr}, 32'h0);
    check_all("rst_mid");
    release_reset();
    for (int i = 0; i < 10; i++) step("cnt_seq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rst.pc", id_pc, 32'h0040_0024);
    jmp_target = 32'h0040_0010;
    step("cnt_jmp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef IFETCH_ICOUNT_EN
    check("cnt.ten", fetch_cnt, 32'd10);
`endif

    // Random traffic, including unaligned and out-of-window targets
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    for (int n = 0; n < 600; n++) begin
      br_target  = ($urandom_range(0, 7) == 0) ? $urandom : RESET_PC + ($urandom_range(0, 4095) << 2);
      jmp_target = RESET_PC + ($urandom_range(0, 4095) << 2);
      epc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : RESET_PC + ($urandom_range(0, 4095) << 2);
      step("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
